// File: rtl/zero_run_encoder_pkg.sv
// Shared types and constants for the zero-run-length encoder.
// record_t is the default-geometry record view used by consumers of the stream.
package zero_run_encoder_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned RUN_W  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RUN_W-1:0]  run;
    logic              last;
  } record_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // Largest run a single record can carry for an r-bit run field.
  function automatic int unsigned max_run(input int unsigned r);
    return (32'd1 << r) - 32'd1;
  endfunction

endpackage

// File: rtl/zero_word_detect.sv
// Unary NOR zero detect: z is high when every bit of the word is zero.
module zero_word_detect #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  output logic         z
);

  assign z = ~|a;

endmodule

// File: rtl/zero_run_encoder.sv
// Streaming zero-run-length encoder: folds runs of all-zero words into a count
// and emits one record per nonzero word, saturated run, or end of packet.
module zero_run_encoder
  import zero_run_encoder_pkg::*;
#(
  parameter int unsigned N = DATA_W,
  parameter int unsigned R = RUN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [N-1:0] a,
  input  logic         a_last,
  output logic         c_valid,
  input  logic         c_ready,
  output logic [N-1:0] c_data,
  output logic [R-1:0] c_run,
  output logic         c_last
);

  // A run reaching this count on a non-final zero word must be flushed now.
  localparam logic [R-1:0] RUN_FLUSH = R'(max_run(R) - 32'd1);

  state_e       state;
  state_e       state_nxt;
  logic [R-1:0] run_cnt;
  logic         z;
  logic         accept;
  logic         emit;

  zero_word_detect #(.N(N)) u_zero_word_detect (
    .a (a),
    .z (z)
  );

  // Handshake qualification and record-producing decision for the current word.
  always_comb begin
    accept = 1'b0;
    emit   = 1'b0;
    accept = a_valid && a_ready;
    emit   = accept && (!z || a_last || (run_cnt == RUN_FLUSH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (emit) state_nxt = FULL;
      FULL:  if (c_ready && !emit) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // The input is open whenever the held record is absent or leaving this cycle.
  always_comb begin
    c_valid = 1'b0;
    a_ready = 1'b1;
    c_valid = (state == FULL);
    a_ready = (state == EMPTY) || c_ready;
  end

  // Run counter only moves on accepted words, so it freezes under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (accept) begin
      if (emit) begin
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + R'(1);
      end
    end
  end

  // Zero-word records carry the run including the current word; data is then 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_data <= '0;
      c_run  <= '0;
      c_last <= 1'b0;
    end else if (emit) begin
      c_data <= a;
      c_run  <= z ? (run_cnt + R'(1)) : run_cnt;
      c_last <= a_last;
    end
  end

endmodule

// File: tb/tb_zero_run_encoder.sv
// Self-checking bench for zero_run_encoder: directed vectors with literal
// expectations, a per-cycle record model, and a stream-reconstruction scoreboard.
module tb_zero_run_encoder;
  import zero_run_encoder_pkg::*;

  localparam int unsigned N       = 8;
  localparam int unsigned R       = 4;
  localparam int unsigned TIMEOUT = 50;

  typedef struct {
    record_t rec;
    int      cyc;
  } logent_t;

  typedef struct packed {
    logic [N-1:0] w;
    logic         l;
  } word_t;

  logic         clk;
  logic         rst_n;
  logic         a_valid;
  logic         a_ready;
  logic [N-1:0] a;
  logic         a_last;
  logic         c_valid;
  logic         c_ready;
  logic [N-1:0] c_data;
  logic [R-1:0] c_run;
  logic         c_last;

  int      tests = 0;
  int      fails = 0;
  int      cyc   = 0;
  int      mz    = 0;
  bit      rand_rdy = 0;
  record_t exp_q[$];
  logent_t got[$];
  word_t   in_q[$];

  zero_run_encoder #(.N(N), .R(R)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a       (a),
    .a_last  (a_last),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .c_data  (c_data),
    .c_run   (c_run),
    .c_last  (c_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic record_t mk(input logic [N-1:0] d, input logic [R-1:0] r, input logic l);
    mk = '{data: d, run: r, last: l};
  endfunction

  task automatic expect_log(input string name, input int idx, input record_t r);
    tests++;
    if (idx >= got.size()) begin
      fails++;
      $display("FAIL %s: record %0d missing, expected %0h", name, idx, r);
    end else if (got[idx].rec !== r) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got[idx].rec, r);
    end
  endtask

  // Mid-cycle monitor: inputs change at posedge+1, outputs at posedge, so all are stable here.
  always @(negedge clk) begin
    record_t r;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      mz = 0;
    end else begin
      check("a_ready", 32'(a_ready), 32'(!c_valid || c_ready));
      check("c_valid", 32'(c_valid), 32'(exp_q.size() != 0));
      if (c_valid && exp_q.size() != 0)
        check("record", 32'({c_data, c_run, c_last}), 32'(exp_q[0]));
      if (c_valid && c_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got.push_back('{rec: mk(c_data, c_run, c_last), cyc: cyc});
      end
      if (a_valid && a_ready) begin
        in_q.push_back('{w: a, l: a_last});
        if (a != '0) begin
          exp_q.push_back(mk(a, R'(mz), a_last));
          mz = 0;
        end else if (a_last || (mz + 1 == 15)) begin
          exp_q.push_back(mk('0, R'(mz + 1), a_last));
          mz = 0;
        end else begin
          mz++;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 c_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [N-1:0] d, input logic l);
    a_valid = 1'b1;
    a       = d;
    a_last  = l;
    for (int i = 0; i < TIMEOUT; i++) begin
      #3;
      if (a_ready) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    tests++;
    fails++;
    $display("FAIL send_timeout: word %0h not accepted within %0d cycles", d, TIMEOUT);
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0;
    a       = '0;
    a_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input string name);
    a_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check({name, "_c_valid"}, 32'(c_valid), 32'd0);
    check({name, "_c_data"},  32'(c_data),  32'd0);
    check({name, "_c_run"},   32'(c_run),   32'd0);
    check({name, "_c_last"},  32'(c_last),  32'd0);
    check({name, "_a_ready"}, 32'(a_ready), 32'd1);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int    bad;
    word_t rec_q[$];
    record_t r;
    logic [N-1:0] d;
    logic l;

    rst_n = 1'b0; a_valid = 1'b0; a = '0; a_last = 1'b0; c_ready = 1'b1;
    #3;
    check("rst_c_valid", 32'(c_valid), 32'd0);
    check("rst_c_data",  32'(c_data),  32'd0);
    check("rst_c_run",   32'(c_run),   32'd0);
    check("rst_c_last",  32'(c_last),  32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Two zeros then a nonzero word.
    got.delete();
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    check("t1_no_rec_for_zeros", 32'(c_valid), 32'd0);
    send(8'h05, 1'b0);
    check("t1_latency", 32'(c_valid), 32'd1);
    check("t1_fields", 32'({c_data, c_run, c_last}), 32'(mk(8'h05, 4'd2, 1'b0)));
    idle(2);
    check("t1_count", 32'(got.size()), 32'd1);
    expect_log("t1_rec", 0, mk(8'h05, 4'd2, 1'b0));

    // Saturated run of 15 zeros.
    got.delete();
    repeat (15) send(8'h00, 1'b0);
    check("t2_sat_valid", 32'(c_valid), 32'd1);
    check("t2_sat_run", 32'(c_run), 32'd15);
    send(8'h01, 1'b0);
    idle(2);
    check("t2_count", 32'(got.size()), 32'd2);
    expect_log("t2_rec0", 0, mk(8'h00, 4'd15, 1'b0));
    expect_log("t2_rec1", 1, mk(8'h01, 4'd0, 1'b0));

    // Packet closed on a zero word, then a single-word packet.
    got.delete();
    send(8'h00, 1'b0);
    send(8'h00, 1'b1);
    send(8'h09, 1'b1);
    idle(2);
    check("t3_count", 32'(got.size()), 32'd2);
    expect_log("t3_rec0", 0, mk(8'h00, 4'd2, 1'b1));
    expect_log("t3_rec1", 1, mk(8'h09, 4'd0, 1'b1));

    // Backpressure hold, then back-to-back drain.
    got.delete();
    c_ready = 1'b0;
    send(8'h03, 1'b0);
    a = 8'h04;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("t4_hold_valid", 32'(c_valid), 32'd1);
      check("t4_hold_data",  32'(c_data),  32'h03);
      check("t4_hold_run",   32'(c_run),   32'd0);
      check("t4_hold_ready", 32'(a_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check("t4_none_out", 32'(got.size()), 32'd0);
    c_ready = 1'b1;
    send(8'h04, 1'b0);
    send(8'h06, 1'b0);
    idle(3);
    check("t4_count", 32'(got.size()), 32'd3);
    expect_log("t4_rec0", 0, mk(8'h03, 4'd0, 1'b0));
    expect_log("t4_rec1", 1, mk(8'h04, 4'd0, 1'b0));
    expect_log("t4_rec2", 2, mk(8'h06, 4'd0, 1'b0));
    if (got.size() == 3) begin
      check("t4_b2b_1", 32'(got[1].cyc - got[0].cyc), 32'd1);
      check("t4_b2b_2", 32'(got[2].cyc - got[1].cyc), 32'd1);
    end else begin
      tests++;
      fails++;
      $display("FAIL t4_b2b: got %0d records, required 3", got.size());
    end

    // Reset while a record is held, then reset with a pending run.
    c_ready = 1'b0;
    send(8'h0e, 1'b0);
    check("t5_held", 32'(c_valid), 32'd1);
    reset_pulse("t5_held_rst");
    c_ready = 1'b1;
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    reset_pulse("t5_run_rst");
    got.delete();
    send(8'h07, 1'b0);
    idle(2);
    check("t5_count", 32'(got.size()), 32'd1);
    expect_log("t5_rec", 0, mk(8'h07, 4'd0, 1'b0));

    // Random stream under random backpressure, decoded back to words.
    got.delete();
    in_q.delete();
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      d = ($urandom_range(0, 9) < 6) ? 8'h00 : N'($urandom_range(1, 255));
      l = ($urandom_range(0, 9) == 0) || (i == 999);
      send(d, l);
    end
    rand_rdy = 1'b0;
    idle(1);
    c_ready = 1'b1;
    idle(5);
    foreach (got[i]) begin
      r = got[i].rec;
      check("t6_run_only_nonzero", 32'(r.data != '0 || r.run != '0), 32'd1);
      for (int j = 0; j < int'(r.run); j++) rec_q.push_back('{w: '0, l: 1'b0});
      if (r.data != '0) rec_q.push_back('{w: r.data, l: 1'b0});
      if (r.last && rec_q.size() != 0) rec_q[rec_q.size() - 1].l = 1'b1;
    end
    check("t6_stream_len", 32'(rec_q.size()), 32'(in_q.size()));
    bad = 0;
    foreach (in_q[i]) begin
      if (i >= rec_q.size() || rec_q[i] !== in_q[i]) bad++;
    end
    check("t6_stream_words", 32'(bad), 32'd0);
    check("t6_in_len", 32'(in_q.size()), 32'd1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
